// File: rtl/regfile_mp.sv
// Multi-port register file with two combinational read ports and two write
// ports (wb1 has priority). An optional bypass forwards same-cycle write data
// to the read ports. A per-register busy scoreboard is set by the issue stage
// and cleared by writeback. Register 0 always reads zero and is never busy.
//
// Port protocol: there is no handshake. A write is committed on the rising
// edge whenever its enable is high and its address is 1..NUM_REGS-1. An issue
// is committed the same way. Reads are purely combinational.
module regfile_mp #(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = 5,
  parameter int BYPASS   = 1,
  parameter logic [NUM_REGS*DATA_W-1:0] INIT_VALS = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   rd_addr1,
  input  logic [ADDR_W-1:0]   rd_addr2,
  output logic [DATA_W-1:0]   rd_data1,
  output logic [DATA_W-1:0]   rd_data2,
  output logic                rd_busy1,
  output logic                rd_busy2,
  input  logic                wb0_en,
  input  logic [ADDR_W-1:0]   wb0_addr,
  input  logic [DATA_W-1:0]   wb0_data,
  input  logic                wb1_en,
  input  logic [ADDR_W-1:0]   wb1_addr,
  input  logic [DATA_W-1:0]   wb1_data,
  input  logic                iss_en,
  input  logic [ADDR_W-1:0]   iss_addr,
  output logic [NUM_REGS-1:0] busy_vec
);

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;

  // Per-register decode of this cycle's writes and issue; bit 0 stays low so
  // register 0 can never be written or marked busy. Out-of-range addresses
  // simply match no register.
  logic [NUM_REGS-1:0] wr0_hit;
  logic [NUM_REGS-1:0] wr1_hit;
  logic [NUM_REGS-1:0] iss_hit;

  // Address decode for both write ports and the issue port
  always_comb begin
    wr0_hit = '0;
    wr1_hit = '0;
    iss_hit = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      wr0_hit[i] = wb0_en && (wb0_addr == ADDR_W'(i));
      wr1_hit[i] = wb1_en && (wb1_addr == ADDR_W'(i));
      iss_hit[i] = iss_en && (iss_addr == ADDR_W'(i));
    end
  end

  // Next register contents and scoreboard; wb1 overrides wb0, and an issue
  // beats a same-cycle writeback because the new producer is still pending
  always_comb begin
    regs_d[0] = '0;
    busy_d    = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (wr1_hit[i])      regs_d[i] = wb1_data;
      else if (wr0_hit[i]) regs_d[i] = wb0_data;
      else                 regs_d[i] = regs_q[i];
      busy_d[i] = iss_hit[i] | (busy_q[i] & ~(wr0_hit[i] | wr1_hit[i]));
    end
  end

  // Read port 1: stored value, or forwarded write data when bypass is on
  always_comb begin
    rd_data1 = '0;
    rd_busy1 = 1'b0;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (rd_addr1 == ADDR_W'(i)) begin
        if ((BYPASS != 0) && wr1_hit[i]) begin
          rd_data1 = wb1_data;
          rd_busy1 = 1'b0;
        end else if ((BYPASS != 0) && wr0_hit[i]) begin
          rd_data1 = wb0_data;
          rd_busy1 = 1'b0;
        end else begin
          rd_data1 = regs_q[i];
          rd_busy1 = busy_q[i];
        end
      end
    end
  end

  // Read port 2: same selection as port 1
  always_comb begin
    rd_data2 = '0;
    rd_busy2 = 1'b0;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (rd_addr2 == ADDR_W'(i)) begin
        if ((BYPASS != 0) && wr1_hit[i]) begin
          rd_data2 = wb1_data;
          rd_busy2 = 1'b0;
        end else if ((BYPASS != 0) && wr0_hit[i]) begin
          rd_data2 = wb0_data;
          rd_busy2 = 1'b0;
        end else begin
          rd_data2 = regs_q[i];
          rd_busy2 = busy_q[i];
        end
      end
    end
  end

  // State update; reset loads the init image and overrides writes and issues
  always_ff @(posedge clk) begin
    if (reset) begin
      regs_q[0] <= '0;
      for (int i = 1; i < NUM_REGS; i++) begin
        regs_q[i] <= INIT_VALS[i*DATA_W +: DATA_W];
      end
      busy_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
      busy_q <= busy_d;
    end
  end

  assign busy_vec = busy_q;

endmodule
